// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one external registered adder
// among NUM_REQ requesters. Grants one operand pair per idle cycle, drives the
// adder, captures its sum one cycle later and returns it tagged with the
// requester ID on a single backpressured response channel.
module adder_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [DATA_W-1:0]          add_in1,
  output logic [DATA_W-1:0]          add_in2,
  input  logic [DATA_W:0]            add_out,
  output logic                       rsp_vld,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W:0]            rsp_sum,
  input  logic                       rsp_rdy,
  output logic                       busy,
  output logic [CNT_W-1:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [DATA_W-1:0]    add_in1_q, add_in1_d;
  logic [DATA_W-1:0]    add_in2_q, add_in2_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W:0]      rsp_sum_q, rsp_sum_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     op_count_q, op_count_d;

  logic                 found;
  logic [ID_W-1:0]      winner;

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    int              idx;
    logic [ID_W-1:0] idx_w;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last_grant_q) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!found && req_vld[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  // One-hot accept pulse, only while idle; held low while reset is asserted
  // so nothing is accepted during an abort.
  always_comb begin
    req_rdy = '0;
    if (reset && (state_q == IDLE) && found) begin
      req_rdy[winner] = 1'b1;
    end
  end

  // Next-state and registered-output logic for the four-phase sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    add_in1_d    = add_in1_q;
    add_in2_d    = add_in2_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          add_in1_d    = req_a[int'(winner)*DATA_W +: DATA_W];
          add_in2_d    = req_b[int'(winner)*DATA_W +: DATA_W];
          id_d         = winner;
          last_grant_d = winner;
          state_d      = ISSUE;
        end
      end
      // Operands are stable; the adder registers the sum at this edge.
      ISSUE: state_d = CAPT;
      CAPT: begin
        rsp_sum_d = add_out;
        rsp_id_d  = id_q;
        rsp_vld_d = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          if (op_count_q != '1) begin
            op_count_d = op_count_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      add_in1_q    <= '0;
      add_in2_q    <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      add_in1_q    <= add_in1_d;
      add_in2_q    <= add_in2_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  assign add_in1  = add_in1_q;
  assign add_in2  = add_in2_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_sum  = rsp_sum_q;
  assign busy     = busy_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Testbench for adder_rr_sched. A behavioural registered adder sits beside
// each scheduler instance. Expected grants come from a round-robin pick over
// the request vector, expected sums from plain a+b, and expected counts from
// a saturating min(). A second instance with a 2-bit counter exercises
// counter saturation within a short run.
module tb_adder_rr_sched;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int DW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_vld;
  logic [DW-1:0]     op_a [NR];
  logic [DW-1:0]     op_b [NR];
  logic [NR*DW-1:0]  req_a, req_b;
  logic              rsp_rdy;

  logic [NR-1:0]     req_rdy;
  logic [DW-1:0]     add_in1, add_in2;
  logic [DW:0]       add_out;
  logic              rsp_vld;
  logic [IW-1:0]     rsp_id;
  logic [DW:0]       rsp_sum;
  logic              busy;
  logic [15:0]       op_count;

  logic [NR-1:0]     s_req_rdy;
  logic [DW-1:0]     s_add_in1, s_add_in2;
  logic [DW:0]       s_add_out;
  logic              s_rsp_vld;
  logic [IW-1:0]     s_rsp_id;
  logic [DW:0]       s_rsp_sum;
  logic              s_busy;
  logic [1:0]        s_op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int m_last;
  int m_cnt;
  int m_cnt_s;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  always #5 clock = ~clock;

  // Registered adders, one cycle of latency.
  always @(posedge clock) add_out   <= 5'(add_in1) + 5'(add_in2);
  always @(posedge clock) s_add_out <= 5'(s_add_in1) + 5'(s_add_in2);

  adder_rr_sched #(.NUM_REQ(NR), .ID_W(IW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_rdy(rsp_rdy),
    .busy(busy), .op_count(op_count)
  );

  adder_rr_sched #(.NUM_REQ(NR), .ID_W(IW), .DATA_W(DW), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(s_req_rdy), .add_in1(s_add_in1), .add_in2(s_add_in2), .add_out(s_add_out),
    .rsp_vld(s_rsp_vld), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum), .rsp_rdy(rsp_rdy),
    .busy(s_busy), .op_count(s_op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Round-robin reference: first requesting index after 'last', or -1.
  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_rdy"},  req_rdy,    0);
    check({tag, "_add_in1"},  add_in1,    0);
    check({tag, "_add_in2"},  add_in2,    0);
    check({tag, "_rsp_vld"},  rsp_vld,    0);
    check({tag, "_rsp_id"},   rsp_id,     0);
    check({tag, "_rsp_sum"},  rsp_sum,    0);
    check({tag, "_busy"},     busy,       0);
    check({tag, "_op_count"}, op_count,   0);
    check({tag, "_sat_cnt"},  s_op_count, 0);
  endtask

  // One full transaction. Entered just after a rising edge with the DUT idle
  // and requests driven; returns just after the edge that re-enters idle.
  // 'bp' is the number of RESP cycles with rsp_rdy held low.
  task automatic serve(input int bp);
    int            w;
    logic [DW-1:0] ea, eb;
    int            es;
    @(negedge clock);
    w = pick(req_vld, m_last);
    check("grant_valid", (w >= 0), 1);
    if (w < 0) w = 0;
    check("grant", req_rdy, 32'(1) << w);
    check("idle_busy", busy, 0);
    ea = op_a[w];
    eb = op_b[w];
    es = int'(ea) + int'(eb);
    m_last = w;
    step();                                  // ISSUE
    @(negedge clock);
    check("issue_rdy", req_rdy, 0);
    check("issue_busy", busy, 1);
    check("issue_in1", add_in1, ea);
    check("issue_in2", add_in2, eb);
    check("issue_vld", rsp_vld, 0);
    step();                                  // CAPT
    if (bp > 0) rsp_rdy = 1'b0;
    @(negedge clock);
    check("capt_vld", rsp_vld, 0);
    step();                                  // RESP, first cycle at T+3
    for (int c = 0; c <= bp; c++) begin
      if (c == bp) rsp_rdy = 1'b1;
      @(negedge clock);
      check("resp_vld", rsp_vld, 1);
      check("resp_id", rsp_id, w);
      check("resp_sum", rsp_sum, es);
      check("resp_rdy_quiet", req_rdy, 0);
      step();
    end
    m_cnt   = (m_cnt + 1 > 16'hFFFF) ? 16'hFFFF : m_cnt + 1;
    m_cnt_s = (m_cnt_s + 1 > 3) ? 3 : m_cnt_s + 1;
    check("done_vld", rsp_vld, 0);
    check("done_busy", busy, 0);
    check("op_count", op_count, m_cnt);
    check("sat_op_count", s_op_count, m_cnt_s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    req_vld = '0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    m_last  = NR - 1;
    m_cnt   = 0;
    m_cnt_s = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset("por");
    step();
    reset = 1'b1;
    @(negedge clock);
    check("noreq_rdy", req_rdy, 0);
    check("noreq_busy", busy, 0);
    step();

    // Single request from requester 0.
    op_a[0] = 4'h3; op_b[0] = 4'h5; req_vld = 4'b0001;
    serve(0);
    req_vld = '0;

    // Full-width sum from requester 2.
    op_a[2] = 4'hF; op_b[2] = 4'hF; req_vld = 4'b0100;
    serve(0);
    req_vld = '0;

    // All requesters continuously asserted: back-to-back round-robin grants.
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 4'($urandom);
      op_b[i] = 4'($urandom);
    end
    req_vld = 4'hF;
    repeat (5) serve(0);
    req_vld = '0;

    // Random request patterns, operands and short backpressure.
    repeat (20) begin
      for (int i = 0; i < NR; i++) begin
        op_a[i] = 4'($urandom);
        op_b[i] = 4'($urandom);
      end
      req_vld = 4'($urandom_range(1, 15));
      serve(int'($urandom_range(0, 3)));
    end
    req_vld = '0;

    // Long backpressure: response held for 10 cycles.
    op_a[3] = 4'hA; op_b[3] = 4'h6; req_vld = 4'b1001;
    serve(10);
    req_vld = '0;

    // Reset asserted during CAPT aborts the operation.
    op_a[0] = 4'h7; op_b[0] = 4'h9; req_vld = 4'b0001;
    @(negedge clock);
    w = pick(req_vld, m_last);
    check("abort_grant", req_rdy, (w < 0) ? 0 : (32'(1) << w));
    step();                                  // ISSUE
    step();                                  // CAPT
    check("abort_capt_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_reset("abort");
    m_last  = NR - 1;
    m_cnt   = 0;
    m_cnt_s = 0;
    step();
    req_vld = 4'b0010;
    op_a[1] = 4'h2; op_b[1] = 4'hC;
    step();
    reset = 1'b1;
    serve(0);
    req_vld = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
